// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared region enum, default 640x480 timing and sizing helpers for vga_timing_gen
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACT   = 2'd0,
    FRONT = 2'd1,
    SYNC  = 2'd2,
    BACK  = 2'd3
  } region_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync_len,
                                    input int bp);
    return active + fp + sync_len + bp;
  endfunction

  // Counter width wide enough to hold total-1; never narrower than one bit.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter plus ACT/FRONT/SYNC/BACK region FSM
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int  ACTIVE   = DEF_H_ACTIVE,
  parameter int  FP_LEN   = DEF_H_FP,
  parameter int  SYNC_LEN = DEF_H_SYNC,
  parameter int  BP_LEN   = DEF_H_BP,
  localparam int TOTAL    = axis_total(ACTIVE, FP_LEN, SYNC_LEN, BP_LEN),
  localparam int W        = cnt_width(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] cnt,
  output region_e      region,
  output logic         wrap
);

  if (ACTIVE < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : g_bad_len
    $error("vga_axis_counter: every region must be at least one unit wide");
  end

  localparam logic [W-1:0] LAST_ACT   = W'(ACTIVE - 1);
  localparam logic [W-1:0] LAST_FRONT = W'(ACTIVE + FP_LEN - 1);
  localparam logic [W-1:0] LAST_SYNC  = W'(ACTIVE + FP_LEN + SYNC_LEN - 1);
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);

  logic [W-1:0] cnt_q, cnt_d;
  region_e      region_q, region_d;

  always_comb begin
    cnt_d    = cnt_q;
    region_d = region_q;
    wrap     = 1'b0;
    if (adv) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wrap  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // The region tracks cnt_q, so it moves on the last unit of the current region.
      case (region_q)
        ACT:     if (cnt_q == LAST_ACT)   region_d = FRONT;
        FRONT:   if (cnt_q == LAST_FRONT) region_d = SYNC;
        SYNC:    if (cnt_q == LAST_SYNC)  region_d = BACK;
        BACK:    if (cnt_q == LAST)       region_d = ACT;
        default: region_d = ACT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      region_q <= ACT;
    end else begin
      cnt_q    <= cnt_d;
      region_q <= region_d;
    end
  end

  assign cnt    = cnt_q;
  assign region = region_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing on a pixel-strobe clock enable; VGA_TIMING_FRAME_CNT_EN adds frame_cnt
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int  H_ACTIVE = DEF_H_ACTIVE,
  parameter int  H_FP     = DEF_H_FP,
  parameter int  H_SYNC   = DEF_H_SYNC,
  parameter int  H_BP     = DEF_H_BP,
  parameter int  V_ACTIVE = DEF_V_ACTIVE,
  parameter int  V_FP     = DEF_V_FP,
  parameter int  V_SYNC   = DEF_V_SYNC,
  parameter int  V_BP     = DEF_V_BP,
  parameter bit  HS_POL   = 1'b0,
  parameter bit  VS_POL   = 1'b0,
  localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int XW       = cnt_width(H_TOTAL),
  localparam int YW       = cnt_width(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  region_e       h_region, v_region;
  logic          h_wrap, v_wrap;

  vga_axis_counter #(
    .ACTIVE  (H_ACTIVE),
    .FP_LEN  (H_FP),
    .SYNC_LEN(H_SYNC),
    .BP_LEN  (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .rst   (rst),
    .adv   (pix_en),
    .cnt   (h_cnt),
    .region(h_region),
    .wrap  (h_wrap)
  );

  // The vertical axis steps once per line, on the strobe that emits the last pixel.
  vga_axis_counter #(
    .ACTIVE  (V_ACTIVE),
    .FP_LEN  (V_FP),
    .SYNC_LEN(V_SYNC),
    .BP_LEN  (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .rst   (rst),
    .adv   (h_wrap),
    .cnt   (v_cnt),
    .region(v_region),
    .wrap  (v_wrap)
  );

  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pix_en) begin
      x_d           = h_cnt;
      y_d           = v_cnt;
      de_d          = (h_region == ACT) && (v_region == ACT);
      hsync_d       = (h_region == SYNC) ? HS_POL : ~HS_POL;
      vsync_d       = (v_region == SYNC) ? VS_POL : ~VS_POL;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        seen_frame_q, seen_frame_d;

  // The first frame after reset is frame 0, so only later frame starts count.
  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    seen_frame_d = seen_frame_q;
    if (frame_start_d) begin
      if (seen_frame_q) frame_cnt_d = frame_cnt_q + 16'd1;
      seen_frame_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q  <= '0;
      seen_frame_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      seen_frame_q <= seen_frame_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule
